// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: per-requester 1-entry holding registers, round-robin grant of up to
// NPORT entries per cycle onto registered PRF write ports. Optional macro: WBARB_STALL_CNT_EN.
module wb_port_arbiter #(
  parameter int NREQ  = 8,
  parameter int NPORT = 4,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                ArbStop,
  input  logic                ArbFlush,
  input  logic [NREQ-1:0]     ReqValid,
  input  logic [NREQ*AW-1:0]  ReqAddr,
  input  logic [NREQ*DW-1:0]  ReqData,
  output logic [NREQ-1:0]     ReqReady,
  output logic [NPORT-1:0]    WrEn,
  output logic [NPORT*AW-1:0] WrAddr,
  output logic [NPORT*DW-1:0] WrData,
  output logic [NREQ-1:0]     Pending
`ifdef WBARB_STALL_CNT_EN
  ,
  output logic [15:0]         StallCnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]           hv_q, hv_d;
  logic [NREQ-1:0][AW-1:0]   ha_q, ha_d;
  logic [NREQ-1:0][DW-1:0]   hd_q, hd_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [NPORT-1:0]          wr_en_q, wr_en_d;
  logic [NPORT*AW-1:0]       wr_addr_q, wr_addr_d;
  logic [NPORT*DW-1:0]       wr_data_q, wr_data_d;

  logic                      active;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           accept;
  logic [NPORT-1:0]          port_vld;
  logic [NPORT-1:0][AW-1:0]  port_addr;
  logic [NPORT-1:0][DW-1:0]  port_data;
  logic [PW-1:0]             last_win;
  logic [PW-1:0]             next_ptr;

  // Handshake: a write is taken on the rising edge where ReqValid[i] & ReqReady[i]. Ready is
  // combinational and depends only on holding state and control, never on ReqValid, so a
  // requester may hold valid indefinitely; a slot granted this cycle can refill in the same edge.
  assign active   = !Rest && !ArbStop && !ArbFlush;
  assign ReqReady = {NREQ{active}} & (~hv_q | grant);
  assign accept   = ReqValid & ReqReady;

  // Rotating scan from ptr_q; the k-th pending slot found drives port k.
  always_comb begin
    int idx;
    int n_win;
    grant     = '0;
    port_vld  = '0;
    port_addr = '0;
    port_data = '0;
    last_win  = ptr_q;
    n_win     = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == idx && hv_q[i] && n_win < NPORT) begin
          grant[i] = 1'b1;
          for (int k = 0; k < NPORT; k++) begin
            if (k == n_win) begin
              port_vld[k]  = 1'b1;
              port_addr[k] = ha_q[i];
              port_data[k] = hd_q[i];
            end
          end
          last_win = PW'(i);
          n_win    = n_win + 1;
        end
      end
    end
  end

  assign next_ptr = (last_win == PW'(NREQ - 1)) ? '0 : last_win + PW'(1);

  always_comb begin
    hv_d      = hv_q;
    ha_d      = ha_q;
    hd_d      = hd_q;
    ptr_d     = ptr_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (ArbFlush) begin
      hv_d    = '0;
      ptr_d   = '0;
      wr_en_d = '0;
    end else if (ArbStop) begin
      wr_en_d = '0;
    end else begin
      wr_en_d = port_vld;
      for (int k = 0; k < NPORT; k++) begin
        if (port_vld[k]) begin
          wr_addr_d[k*AW +: AW] = port_addr[k];
          wr_data_d[k*DW +: DW] = port_data[k];
        end
      end
      // A load in the same cycle as a grant keeps the slot full with the new entry.
      hv_d = hv_q & ~grant;
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          hv_d[i] = 1'b1;
          ha_d[i] = ReqAddr[i*AW +: AW];
          hd_d[i] = ReqData[i*DW +: DW];
        end
      end
      if (|grant) ptr_d = next_ptr;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      hv_q      <= '0;
      ha_q      <= '0;
      hd_q      <= '0;
      ptr_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      hv_q      <= hv_d;
      ha_q      <= ha_d;
      hd_q      <= hd_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign WrEn    = wr_en_q;
  assign WrAddr  = wr_addr_q;
  assign WrData  = wr_data_q;
  assign Pending = hv_q;

`ifdef WBARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts overloaded cycles; survives flush so the figure spans the whole run.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ArbStop && $countones(hv_q) > NPORT && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rest) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model and a write scoreboard.
module tb_wb_port_arbiter;
  localparam int NREQ  = 8;
  localparam int NPORT = 4;
  localparam int AW    = 7;
  localparam int DW    = 32;

  logic                Clk;
  logic                Rest;
  logic                ArbStop;
  logic                ArbFlush;
  logic [NREQ-1:0]     ReqValid;
  logic [NREQ*AW-1:0]  ReqAddr;
  logic [NREQ*DW-1:0]  ReqData;
  logic [NREQ-1:0]     ReqReady;
  logic [NPORT-1:0]    WrEn;
  logic [NPORT*AW-1:0] WrAddr;
  logic [NPORT*DW-1:0] WrData;
  logic [NREQ-1:0]     Pending;
`ifdef WBARB_STALL_CNT_EN
  logic [15:0]         StallCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [NREQ-1:0]     m_hv;
  logic [AW-1:0]       m_ha [NREQ];
  logic [DW-1:0]       m_hd [NREQ];
  int                  m_ptr;
  logic [NPORT-1:0]    m_en;
  logic [NPORT*AW-1:0] m_addr;
  logic [NPORT*DW-1:0] m_data;
  int                  m_stall;
  logic [NREQ-1:0]     exp_rdy;
  logic [NREQ-1:0]     obs_rdy;
  bit                  sb_on;
  logic [AW+DW-1:0]    exp_q [$];

  wb_port_arbiter #(.NREQ(NREQ), .NPORT(NPORT), .AW(AW), .DW(DW)) dut (
    .Clk      (Clk),
    .Rest     (Rest),
    .ArbStop  (ArbStop),
    .ArbFlush (ArbFlush),
    .ReqValid (ReqValid),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .ReqReady (ReqReady),
    .WrEn     (WrEn),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Pending  (Pending)
`ifdef WBARB_STALL_CNT_EN
    ,
    .StallCnt (StallCnt)
`endif
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic rand_payload();
    for (int i = 0; i < NREQ; i++) begin
      ReqAddr[i*AW +: AW] = AW'($urandom_range(0, 127));
      ReqData[i*DW +: DW] = $urandom;
    end
  endtask

  // One clock: sample ready before the edge, advance model at the edge, settle after it.
  task automatic cycle();
    int win[$];
    logic [NREQ-1:0] grant;
    logic run;
    #1;
    run = !Rest && !ArbStop && !ArbFlush;
    for (int i = 0; i < NREQ; i++) begin
      int idx = (m_ptr + i) % NREQ;
      if (m_hv[idx] && win.size() < NPORT) win.push_back(idx);
    end
    grant = '0;
    if (run) foreach (win[k]) grant[win[k]] = 1'b1;
    exp_rdy = {NREQ{run}} & (~m_hv | grant);
    obs_rdy = ReqReady;
    @(posedge Clk);
    if (Rest) begin
      m_hv = '0; m_ptr = 0; m_en = '0; m_addr = '0; m_data = '0; m_stall = 0;
    end else begin
      if (!ArbStop && $countones(m_hv) > NPORT && m_stall < 65535) m_stall++;
      if (ArbFlush) begin
        m_hv = '0; m_ptr = 0; m_en = '0;
      end else if (ArbStop) begin
        m_en = '0;
      end else begin
        m_en = '0;
        foreach (win[k]) begin
          m_en[k] = 1'b1;
          m_addr[k*AW +: AW] = m_ha[win[k]];
          m_data[k*DW +: DW] = m_hd[win[k]];
          if (sb_on) exp_q.push_back({m_ha[win[k]], m_hd[win[k]]});
          m_hv[win[k]] = 1'b0;
        end
        if (win.size() > 0) m_ptr = (win[win.size()-1] + 1) % NREQ;
        for (int i = 0; i < NREQ; i++) begin
          if (ReqValid[i] && exp_rdy[i]) begin
            m_hv[i] = 1'b1;
            m_ha[i] = ReqAddr[i*AW +: AW];
            m_hd[i] = ReqData[i*DW +: DW];
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Rest = 1'b1; ArbStop = 1'b0; ArbFlush = 1'b0; ReqValid = '1;
    rand_payload();
    repeat (2) begin
      cycle();
      n_tests++;
      if (obs_rdy !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 00000000", obs_rdy); end
      n_tests++;
      if (WrEn !== '0) begin n_fail++; $display("FAIL reset_wren: got %b want 0000", WrEn); end
    end
    n_tests++;
    if (Pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %b want 00000000", Pending); end
    n_tests++;
    if (WrAddr !== '0 || WrData !== '0) begin
      n_fail++; $display("FAIL reset_wrbus: got addr %h data %h want 0", WrAddr, WrData);
    end
    Rest = 1'b0; ReqValid = '0;
  endtask

  task automatic test_single_write();
    ReqValid = NREQ'(1);
    ReqAddr[0 +: AW] = 7'd33;
    ReqData[0 +: DW] = 32'hDEADBEEF;
    cycle();
    n_tests++;
    if (obs_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", obs_rdy[0]); end
    n_tests++;
    if (Pending !== NREQ'(1)) begin n_fail++; $display("FAIL single_pending_load: got %b want 00000001", Pending); end
    ReqValid = '0;
    cycle();
    n_tests++;
    if (WrEn !== NPORT'(1)) begin n_fail++; $display("FAIL single_wren: got %b want 0001", WrEn); end
    n_tests++;
    if (WrAddr[AW-1:0] !== 7'd33) begin n_fail++; $display("FAIL single_addr: got %0d want 33", WrAddr[AW-1:0]); end
    n_tests++;
    if (WrData[DW-1:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_data: got %h want deadbeef", WrData[DW-1:0]);
    end
    n_tests++;
    if (Pending !== '0) begin n_fail++; $display("FAIL single_pending_clear: got %b want 0", Pending); end
  endtask

  task automatic test_overload();
    logic [NREQ*AW-1:0] sa;
    logic [NREQ*DW-1:0] sd;
    ArbFlush = 1'b1; ReqValid = '0;
    cycle();
    ArbFlush = 1'b0;
    rand_payload(); sa = ReqAddr; sd = ReqData;
    ReqValid = '1;
    cycle();
    n_tests++;
    if (obs_rdy !== '1) begin n_fail++; $display("FAIL ovl_accept: got %b want 11111111", obs_rdy); end
    ReqValid = '0;
    cycle();
    n_tests++;
    if (obs_rdy !== 8'h0F) begin n_fail++; $display("FAIL ovl_ready_c1: got %b want 00001111", obs_rdy); end
    n_tests++;
    if (WrEn !== '1 || WrAddr !== sa[4*AW-1:0] || WrData !== sd[4*DW-1:0]) begin
      n_fail++; $display("FAIL ovl_grant_c1: got en %b addr %h want 1111 addr %h", WrEn, WrAddr, sa[4*AW-1:0]);
    end
    n_tests++;
    if (Pending !== 8'hF0) begin n_fail++; $display("FAIL ovl_pending_c1: got %b want 11110000", Pending); end
`ifdef WBARB_STALL_CNT_EN
    n_tests++;
    if (StallCnt !== 16'd1) begin n_fail++; $display("FAIL ovl_stallcnt: got %0d want 1", StallCnt); end
`endif
    cycle();
    n_tests++;
    if (WrEn !== '1 || WrAddr !== sa[8*AW-1:4*AW] || WrData !== sd[8*DW-1:4*DW]) begin
      n_fail++; $display("FAIL ovl_grant_c2: got en %b addr %h want 1111 addr %h", WrEn, WrAddr, sa[8*AW-1:4*AW]);
    end
    n_tests++;
    if (Pending !== '0) begin n_fail++; $display("FAIL ovl_pending_c2: got %b want 0", Pending); end
    // pointer back at 0: requester 0 must land on port 0 ahead of requester 7
    rand_payload(); sa = ReqAddr;
    ReqValid = 8'h81;
    cycle();
    ReqValid = '0;
    cycle();
    n_tests++;
    if (WrEn !== 4'b0011 || WrAddr[AW-1:0] !== sa[AW-1:0] || WrAddr[2*AW-1:AW] !== sa[8*AW-1:7*AW]) begin
      n_fail++; $display("FAIL ovl_ptr_wrap: got en %b addr %h", WrEn, WrAddr);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ*AW-1:0] sa;
    ArbFlush = 1'b1; ReqValid = '0;
    cycle();
    ArbFlush = 1'b0;
    rand_payload(); sa = ReqAddr;
    ReqValid = 8'h20;
    cycle();
    ReqValid = 8'hC7;
    cycle();
    n_tests++;
    if (WrEn !== 4'b0001 || WrAddr[AW-1:0] !== sa[5*AW +: AW] || Pending !== 8'hC7) begin
      n_fail++; $display("FAIL rr_setup: got en %b pend %b want 0001 11000111", WrEn, Pending);
    end
    ReqValid = '0;
    cycle();
    n_tests++;
    if (obs_rdy !== 8'hFB) begin n_fail++; $display("FAIL rr_ready: got %b want 11111011", obs_rdy); end
    n_tests++;
    if (WrEn !== '1 || WrAddr !== {sa[1*AW +: AW], sa[0 +: AW], sa[7*AW +: AW], sa[6*AW +: AW]}) begin
      n_fail++; $display("FAIL rr_order: got en %b addr %h", WrEn, WrAddr);
    end
    n_tests++;
    if (Pending !== 8'h04) begin n_fail++; $display("FAIL rr_pending: got %b want 00000100", Pending); end
    cycle();
    n_tests++;
    if (WrEn !== 4'b0001 || WrAddr[AW-1:0] !== sa[2*AW +: AW] || Pending !== '0) begin
      n_fail++; $display("FAIL rr_next: got en %b addr %h pend %b", WrEn, WrAddr[AW-1:0], Pending);
    end
  endtask

  task automatic test_stop();
    logic [NREQ*AW-1:0] sa;
    rand_payload(); sa = ReqAddr;
    ReqValid = 8'h12;
    cycle();
    n_tests++;
    if (Pending !== 8'h12) begin n_fail++; $display("FAIL stop_load: got %b want 00010010", Pending); end
    ArbStop = 1'b1; ReqValid = '1;
    repeat (3) begin
      cycle();
      n_tests++;
      if (obs_rdy !== '0 || WrEn !== '0 || Pending !== 8'h12) begin
        n_fail++; $display("FAIL stop_hold: got rdy %b en %b pend %b want 0 0 00010010", obs_rdy, WrEn, Pending);
      end
    end
    ArbStop = 1'b0; ReqValid = '0;
    cycle();
    n_tests++;
    if (WrEn !== 4'b0011 || WrAddr[AW-1:0] !== sa[4*AW +: AW] || WrAddr[2*AW-1:AW] !== sa[1*AW +: AW]) begin
      n_fail++; $display("FAIL stop_release: got en %b addr %h", WrEn, WrAddr);
    end
    n_tests++;
    if (Pending !== '0) begin n_fail++; $display("FAIL stop_drain: got %b want 0", Pending); end
  endtask

  task automatic test_flush();
    rand_payload();
    ReqValid = 8'h1F;
    cycle();
    n_tests++;
    if (Pending !== 8'h1F) begin n_fail++; $display("FAIL flush_load: got %b want 00011111", Pending); end
    ArbFlush = 1'b1; ReqValid = 8'h80;
    cycle();
    n_tests++;
    if (obs_rdy !== '0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", obs_rdy); end
    n_tests++;
    if (Pending !== '0 || WrEn !== '0) begin
      n_fail++; $display("FAIL flush_clear: got pend %b en %b want 0 0", Pending, WrEn);
    end
    ArbFlush = 1'b0; ReqValid = '0;
    cycle();
    n_tests++;
    if (WrEn !== '0 || Pending !== '0) begin
      n_fail++; $display("FAIL flush_rob_dropped: got en %b pend %b want 0 0", WrEn, Pending);
    end
  endtask

  task automatic test_random();
    logic [AW+DW-1:0] got;
    sb_on = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        ReqValid = NREQ'($urandom);
        rand_payload();
        ArbStop  = ($urandom_range(0, 7) == 0);
        ArbFlush = ($urandom_range(0, 15) == 0);
      end else begin
        ReqValid = '0; ArbStop = 1'b0; ArbFlush = 1'b0;
      end
      cycle();
      n_tests++;
      if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_rdy, exp_rdy); end
      n_tests++;
      if (Pending !== m_hv) begin n_fail++; $display("FAIL rnd_pending c%0d: got %b want %b", c, Pending, m_hv); end
      n_tests++;
      if (WrEn !== m_en || WrAddr !== m_addr || WrData !== m_data) begin
        n_fail++; $display("FAIL rnd_wrport c%0d: got en %b addr %h want en %b addr %h", c, WrEn, WrAddr, m_en, m_addr);
      end
      for (int k = 0; k < NPORT; k++) begin
        if (WrEn[k] === 1'b1) begin
          got = {WrAddr[k*AW +: AW], WrData[k*DW +: DW]};
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rnd_sb_extra c%0d port%0d: got %h want none", c, k, got);
          end else if (got !== exp_q[0]) begin
            n_fail++; $display("FAIL rnd_sb c%0d port%0d: got %h want %h", c, k, got, exp_q[0]);
            void'(exp_q.pop_front());
          end else begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_sb_left: got %0d want 0", exp_q.size()); end
    sb_on = 1'b0;
  endtask

`ifdef WBARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    n_tests++;
    if (StallCnt !== 16'(m_stall)) begin n_fail++; $display("FAIL stall_track: got %0d want %0d", StallCnt, m_stall); end
    rand_payload();
    ReqValid = '1;
    repeat (70000) cycle();
    ReqValid = '0;
    n_tests++;
    if (StallCnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat: got %h want ffff", StallCnt); end
  endtask
`endif

  initial begin
    Rest = 1'b1; ArbStop = 1'b0; ArbFlush = 1'b0; ReqValid = '0; ReqAddr = '0; ReqData = '0;
    m_hv = '0; m_ptr = 0; m_en = '0; m_addr = '0; m_data = '0; m_stall = 0; sb_on = 1'b0;
    for (int i = 0; i < NREQ; i++) begin m_ha[i] = '0; m_hd[i] = '0; end
    test_reset();
    test_single_write();
    test_overload();
    test_round_robin();
    test_stop();
    test_flush();
    test_random();
`ifdef WBARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
